// File: rtl/knn_majority_vote.sv
`default_nettype none
// ============================================================================
// Module      : knn_majority_vote
// Description : Sequential K-nearest-neighbour majority voter. An accepted,
//               nearest-first label list is counted one entry per cycle into
//               per-class vote counters. The counters are then scanned one
//               class per cycle. The class with the most votes wins. On a
//               tie, the class whose nearest member ranks closest wins.
// Ports       : clk                       - clock
//               rst                       - synchronous active-high reset
//               valid_sort                - sorted list available (IDLE only)
//               k_nearest_neighbours_type - packed labels, entry 0 nearest
//               inferred_type             - winning class, held until next
//               inference_done            - one-cycle result strobe
//               winner_votes              - vote count of the winner
//               busy                      - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module knn_majority_vote #(
    parameter int K      = 5,
    parameter int TYPE_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_sort,
    input  logic [TYPE_W*K-1:0]        k_nearest_neighbours_type,
    output logic [TYPE_W-1:0]          inferred_type,
    output logic                       inference_done,
    output logic [$clog2(K+1)-1:0]     winner_votes,
    output logic                       busy
);

    localparam int NUM_CLASSES = 2 ** TYPE_W;
    localparam int CNT_W       = $clog2(K + 1);
    localparam int RANK_W      = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;

    // Latched list, shifted right one entry per COUNT cycle so the entry
    // being counted is always in the low bits.
    logic [TYPE_W*K-1:0]  r_list;
    logic [RANK_W-1:0]    r_entry_idx;
    logic [TYPE_W-1:0]    r_class_idx;

    logic [CNT_W-1:0]     r_cnt  [NUM_CLASSES];
    logic [RANK_W-1:0]    r_rank [NUM_CLASSES];

    logic                 r_best_valid;
    logic [TYPE_W-1:0]    r_best_class;
    logic [CNT_W-1:0]     r_best_cnt;
    logic [RANK_W-1:0]    r_best_rank;

    logic [TYPE_W-1:0]    w_label;
    logic                 w_last_entry;
    logic                 w_last_class;
    logic [CNT_W-1:0]     w_scan_cnt;
    logic [RANK_W-1:0]    w_scan_rank;
    logic                 w_take;

    assign w_label      = r_list[TYPE_W-1:0];
    assign w_last_entry = (r_entry_idx == RANK_W'(K - 1));
    assign w_last_class = &r_class_idx;
    assign w_scan_cnt   = r_cnt[r_class_idx];
    assign w_scan_rank  = r_rank[r_class_idx];

    // Class under scan replaces the running best on more votes, or on equal
    // votes with a nearer first occurrence. Empty classes never win.
    assign w_take = (w_scan_cnt != '0) &&
                    (!r_best_valid ||
                     (w_scan_cnt > r_best_cnt) ||
                     ((w_scan_cnt == r_best_cnt) && (w_scan_rank < r_best_rank)));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (valid_sort)   w_state_next = S_COUNT;
            S_COUNT: if (w_last_entry) w_state_next = S_SCAN;
            S_SCAN:  if (w_last_class) w_state_next = S_DONE;
            S_DONE:                    w_state_next = S_IDLE;
            default:                   w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy           = 1'b0;
        inference_done = 1'b0;
        if (r_state != S_IDLE) busy           = 1'b1;
        if (r_state == S_DONE) inference_done = 1'b1;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_list        <= '0;
            r_entry_idx   <= '0;
            r_class_idx   <= '0;
            r_best_valid  <= 1'b0;
            r_best_class  <= '0;
            r_best_cnt    <= '0;
            r_best_rank   <= '0;
            inferred_type <= '0;
            winner_votes  <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_cnt[c]  <= '0;
                r_rank[c] <= RANK_W'(K - 1);
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_sort) begin
                        r_list      <= k_nearest_neighbours_type;
                        r_entry_idx <= '0;
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            r_cnt[c]  <= '0;
                            r_rank[c] <= RANK_W'(K - 1);
                        end
                    end
                end
                S_COUNT: begin
                    r_cnt[w_label] <= r_cnt[w_label] + CNT_W'(1);
                    // A zero counter means this is the label's first
                    // (nearest) occurrence.
                    if (r_cnt[w_label] == '0) begin
                        r_rank[w_label] <= r_entry_idx;
                    end
                    r_list      <= r_list >> TYPE_W;
                    r_entry_idx <= r_entry_idx + RANK_W'(1);
                    if (w_last_entry) begin
                        r_class_idx  <= '0;
                        r_best_valid <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (w_take) begin
                        r_best_valid <= 1'b1;
                        r_best_class <= r_class_idx;
                        r_best_cnt   <= w_scan_cnt;
                        r_best_rank  <= w_scan_rank;
                    end
                    r_class_idx <= r_class_idx + TYPE_W'(1);
                    // Publish on the last scan step, folding in that final
                    // comparison, so results are visible in the DONE cycle.
                    if (w_last_class) begin
                        inferred_type <= w_take ? r_class_idx : r_best_class;
                        winner_votes  <= w_take ? w_scan_cnt  : r_best_cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_knn_majority_vote.sv
`default_nettype none
// ============================================================================
// Module      : tb_knn_majority_vote
// Description : Self-checking bench for knn_majority_vote. Instance A uses
//               K=5, TYPE_W=2; instance B uses K=1, TYPE_W=1. Expected
//               results are queued when a list is driven and popped when the
//               DUT strobes inference_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_majority_vote;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_a;
    logic [9:0] list_a;
    logic [1:0] type_a;
    logic       done_a;
    logic [2:0] votes_a;
    logic       busy_a;
    logic       valid_b;
    logic [0:0] list_b;
    logic [0:0] type_b;
    logic       done_b;
    logic [0:0] votes_b;
    logic       busy_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0] t;
        logic [2:0] v;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic [1:0] hold_ta = '0;
    logic [2:0] hold_va = '0;
    logic [0:0] hold_tb = '0;
    logic [0:0] hold_vb = '0;

    knn_majority_vote #(.K(5), .TYPE_W(2)) u_dut_a (
        .clk                       (clk),
        .rst                       (rst),
        .valid_sort                (valid_a),
        .k_nearest_neighbours_type (list_a),
        .inferred_type             (type_a),
        .inference_done            (done_a),
        .winner_votes              (votes_a),
        .busy                      (busy_a)
    );

    knn_majority_vote #(.K(1), .TYPE_W(1)) u_dut_b (
        .clk                       (clk),
        .rst                       (rst),
        .valid_sort                (valid_b),
        .k_nearest_neighbours_type (list_b),
        .inferred_type             (type_b),
        .inference_done            (done_b),
        .winner_votes              (votes_b),
        .busy                      (busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] pack5(input int e0, input int e1, input int e2,
                                         input int e3, input int e4);
        return {e4[1:0], e3[1:0], e2[1:0], e1[1:0], e0[1:0]};
    endfunction

    // Reference: largest count wins; among classes sharing it, the one
    // appearing earliest in the list wins.
    task automatic model5(input logic [9:0] v, output logic [1:0] t, output logic [2:0] n);
        int cnt[4];
        int mx;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int i = 0; i < 5; i++) cnt[v[i*2 +: 2]]++;
        mx = 0;
        for (int c = 0; c < 4; c++) if (cnt[c] > mx) mx = cnt[c];
        t = 2'd0;
        for (int i = 4; i >= 0; i--) if (cnt[v[i*2 +: 2]] == mx) t = v[i*2 +: 2];
        n = 3'(mx);
    endtask

    // Monitors: every non-reset cycle either a strobe matches the queue head
    // (value and cycle) or the held outputs are unchanged.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_a) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    chk("a_type", type_a, e.t);
                    chk("a_votes", votes_a, e.v);
                    chk("a_done_cycle", cyc, e.cyc);
                    hold_ta = e.t;
                    hold_va = e.v;
                end
            end else begin
                chk("a_hold_type", type_a, hold_ta);
                chk("a_hold_votes", votes_a, hold_va);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done_b) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    chk("b_type", type_b, e.t);
                    chk("b_votes", votes_b, e.v);
                    chk("b_done_cycle", cyc, e.cyc);
                    hold_tb = e.t[0:0];
                    hold_vb = e.v[0:0];
                end
            end else begin
                chk("b_hold_type", type_b, hold_tb);
                chk("b_hold_votes", votes_b, hold_vb);
            end
        end
    end

    // Called at a negedge; valid is sampled at the next posedge.
    task automatic send_a(input logic [9:0] l, input bit push, input logic [1:0] t,
                          input logic [2:0] n);
        valid_a = 1'b1;
        list_a  = l;
        if (push) qa.push_back('{t: t, v: n, cyc: cyc + 1 + 5 + 4});
        @(negedge clk);
        valid_a = 1'b0;
        list_a  = 10'($urandom);
    endtask

    task automatic send_b(input logic [0:0] l);
        valid_b = 1'b1;
        list_b  = l;
        qb.push_back('{t: {1'b0, l}, v: 3'd1, cyc: cyc + 1 + 1 + 2});
        @(negedge clk);
        valid_b = 1'b0;
        list_b  = 1'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy_a || busy_b || qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk(tag, 1, 0);
    endtask

    initial begin
        int n0;
        logic [9:0] l;
        logic [1:0] et;
        logic [2:0] ev;

        rst     = 1'b1;
        valid_a = 1'b0;
        list_a  = '0;
        valid_b = 1'b0;
        list_b  = '0;
        repeat (3) @(negedge clk);
        chk("rst_type_a", type_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_votes_a", votes_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_type_b", type_b, 0);
        chk("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // Unanimous list, also checks busy rise
        send_a(pack5(2, 2, 2, 2, 2), 1, 2'd2, 3'd5);
        chk("busy_rise_a", busy_a, 1);
        wait_idle("timeout_unanimous");

        send_a(pack5(1, 3, 3, 1, 3), 1, 2'd3, 3'd3);
        wait_idle("timeout_majority");

        // Ties resolved by nearest first occurrence
        send_a(pack5(0, 2, 2, 0, 1), 1, 2'd0, 3'd2);
        wait_idle("timeout_tie0");
        send_a(pack5(2, 0, 0, 2, 1), 1, 2'd2, 3'd2);
        wait_idle("timeout_tie2");
        send_a(pack5(3, 0, 1, 2, 1), 1, 2'd1, 3'd2);
        wait_idle("timeout_tie_late");
        send_a(pack5(3, 0, 1, 2, 0), 1, 2'd0, 3'd2);
        wait_idle("timeout_tie_mid");

        // Random lists against the reference model
        for (int r = 0; r < 6; r++) begin
            l = 10'($urandom);
            model5(l, et, ev);
            send_a(l, 1, et, ev);
            wait_idle("timeout_random");
        end

        // valid during busy is ignored; back-to-back re-issue accepted
        n0 = cyc;
        send_a(pack5(0, 0, 3, 3, 3), 1, 2'd3, 3'd3);
        repeat (2) @(negedge clk);
        send_a(pack5(1, 1, 1, 1, 1), 0, 2'd0, 3'd0);
        chk("busy_mid_a", busy_a, 1);
        while (cyc < n0 + 11) @(negedge clk);
        chk("busy_fall_a", busy_a, 0);
        send_a(pack5(1, 1, 1, 1, 1), 1, 2'd1, 3'd5);
        wait_idle("timeout_reissue");

        // Reset during COUNT aborts; valid in the reset cycle is dropped
        n0 = cyc;
        send_a(pack5(3, 3, 3, 0, 0), 1, 2'd3, 3'd3);
        while (cyc < n0 + 4) @(negedge clk);
        rst     = 1'b1;
        valid_a = 1'b1;
        list_a  = pack5(2, 2, 2, 2, 2);
        hold_ta = '0;
        hold_va = '0;
        qa.delete();
        @(negedge clk);
        rst     = 1'b0;
        valid_a = 1'b0;
        chk("abort_type_a", type_a, 0);
        chk("abort_votes_a", votes_a, 0);
        chk("abort_busy_a", busy_a, 0);
        @(negedge clk);
        chk("abort_no_accept_a", busy_a, 0);
        repeat (12) @(negedge clk);
        send_a(pack5(1, 0, 1, 0, 2), 1, 2'd1, 3'd2);
        wait_idle("timeout_after_abort");

        // Single-neighbour instance
        send_b(1'b1);
        wait_idle("timeout_b1");
        send_b(1'b0);
        wait_idle("timeout_b0");
        send_b(1'b1);
        wait_idle("timeout_b1b");

        repeat (5) @(negedge clk);
        chk("pending_a", qa.size(), 0);
        chk("pending_b", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/knn_majority_vote.md
# knn_majority_vote

Sequential K-nearest-neighbour voting stage: it consumes the nearest-first type list produced by the distance sorter and outputs the class with the most votes among the K nearest neighbours. Ties go to the class whose nearest member ranks closest. It sits directly downstream of `distance_sort` inside `knn_system`, in place of the combinational voter. Each accepted list is counted one entry per cycle into per-class counters, then the counters are scanned one class per cycle.

## Interface
Parameters:
- `K`, default 5: number of neighbours voted; K ≥ 1.
- `TYPE_W`, default 2: class label width; number of classes is C = 2^TYPE_W.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `valid_sort`  in  1  sorted list available; sampled only in IDLE.
- `k_nearest_neighbours_type`  in  TYPE_W*K  packed labels; entry i is `[(i+1)*TYPE_W-1 -: TYPE_W]`; entry 0 is the nearest.
- `inferred_type`  out  TYPE_W  winning class; held until the next result.
- `inference_done`  out  1  one-cycle pulse, valid with the new `inferred_type`.
- `winner_votes`  out  clog2(K+1)  vote count of the winner; updates with `inferred_type`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, COUNT, SCAN, DONE.
- **IDLE**
  - On `valid_sort`=1: latch the whole input vector into an internal register.
  - Clear all C vote counters to 0, clear all C first-rank registers to K−1, reset the entry index to 0.
  - Go to COUNT.
- **COUNT** (K cycles): for the latched entry at index i, with label t:
  - increment `cnt[t]`;
  - if this is the first occurrence of t, set `rank[t]`=i (first occurrence only);
  - after i=K−1, reset the class index to 0 and go to SCAN.
- **SCAN** (C cycles):
  - Running best starts invalid.
  - Class c replaces the best if `cnt[c]`>0 and either:
    - the best is invalid, or
    - `cnt[c]` > best count, or
    - `cnt[c]` = best count and `rank[c]` < best rank.
  - After c=C−1, go to DONE.
- **DONE** (1 cycle):
  - Register the best class into `inferred_type` and its count into `winner_votes`.
  - Pulse `inference_done`.
  - Return to IDLE.
- Arithmetic:
  - Counters are clog2(K+1) bits and cannot overflow, since the total number of votes is K.
  - Ranks are max(1, clog2(K)) bits.
- `valid_sort` in COUNT, SCAN or DONE is ignored and not queued; upstream must wait for `busy`=0.
- Input changes after acceptance have no effect, because only the latched copy is used.

## Timing
- If `valid_sort` is accepted in cycle t:
  - entry i is counted in cycle t+1+i;
  - class c is scanned in cycle t+K+1+c;
  - `inference_done`=1 in cycle t+K+C+1, with `inferred_type`/`winner_votes` new in that same cycle.
- Latency is K+C+1 cycles from acceptance to done. The earliest next acceptance is cycle t+K+C+2.
- `busy` rises in cycle t+1 and falls in cycle t+K+C+2.
- `inference_done` is exactly 1 cycle wide.
- Reset values: `inferred_type`=0, `inference_done`=0, `winner_votes`=0, `busy`=0, state IDLE, all counters 0.
- Reset wins over every other event in the same cycle.
- Reset mid-COUNT or mid-SCAN aborts the vote with no `inference_done` and restores all reset values; the previous `inferred_type` is lost.
- `valid_sort` in the cycle rst deasserts: not accepted (state is IDLE only from the following cycle).

## Test plan
- K=5, TYPE_W=2, list {2,2,2,2,2} (entry0..4), pulse at cycle t → `inference_done` at t+10, `inferred_type`=2, `winner_votes`=5.
- List {1,3,3,1,3} → `inferred_type`=3, `winner_votes`=3, no output change before t+10.
- Tie list {0,2,2,0,1} (counts 0:2, 2:2; rank 0:0, rank 2:1) → `inferred_type`=0, `winner_votes`=2; list {2,0,0,2,1} → `inferred_type`=2.
- Second `valid_sort` at t+3 with list {1,1,1,1,1} → ignored, result of the first list only, single done pulse; re-issue at t+11 → accepted, done at t+21 with `inferred_type`=1.
- rst high at t+4 (COUNT) → no done pulse, all outputs 0 next cycle, next `valid_sort` processed normally.
- K=1, TYPE_W=1, list {1} → done at t+4, `inferred_type`=1, `winner_votes`=1.
